// File: rtl/uart_intc.sv
// uart_intc: 16550 interrupt controller; prioritises LS/RDA/TO/THRE into the IIR code and irq.
// The RX character-timeout counter is only built when UART_RX_TIMEOUT_EN is defined.
module uart_intc #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    cfg_int_en,
    input  logic                          cfg_fifo_enable,
    input  logic [1:0]                    cfg_fifo_trig,
    input  logic [1:0]                    cfg_word_len,
    input  logic                          cfg_stop_bit,
    input  logic                          cfg_parity_en,
    input  logic                          int_rx_line_status,
    input  logic                          rx_valid,
    input  logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count,
    input  logic                          rx_push,
    input  logic                          rd_rhr,
    input  logic                          thr_empty,
    input  logic                          wr_thr,
    input  logic                          rd_iir,
    input  logic                          rx_bit_tick,
    output logic [3:0]                    int_code,
    output logic                          irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            r_thr_empty_q;
    logic            r_ier1_q;
    logic            r_thre_pend;
    logic            r_timeout_pend;
    logic [CW-1:0]   w_trig;
    logic            w_ls;
    logic            w_rda;
    logic            w_to;
    logic            w_thre;
    logic            w_thre_set;
    logic [3:0]      w_code;
    logic            w_unused;

    assign w_trig = cfg_fifo_trig == 2'd0 ? CW'(1) : cfg_fifo_trig == 2'd1 ? CW'(4) :
                    cfg_fifo_trig == 2'd2 ? CW'(8) : CW'(14);
    assign w_ls   = cfg_int_en[2] & int_rx_line_status;
    assign w_rda  = cfg_int_en[0] & (cfg_fifo_enable ? rx_fifo_count >= w_trig : rx_valid);
    assign w_to   = cfg_int_en[0] & r_timeout_pend;
    assign w_thre = cfg_int_en[1] & r_thre_pend;
    assign w_code = w_ls ? 4'b0110 : w_rda ? 4'b0100 : w_to ? 4'b1100 : w_thre ? 4'b0010 : 4'b0001;
    // Enabling THRE while the transmitter is already empty must still raise an interrupt
    assign w_thre_set = (thr_empty & ~r_thr_empty_q) | (cfg_int_en[1] & ~r_ier1_q & thr_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            int_code      <= 4'b0001;
            irq           <= 1'b0;
            r_thre_pend   <= 1'b0;
            r_thr_empty_q <= 1'b1;
            r_ier1_q      <= 1'b0;
        end else begin
            int_code      <= w_code;
            irq           <= w_code != 4'b0001;
            r_thr_empty_q <= thr_empty;
            r_ier1_q      <= cfg_int_en[1];
            r_thre_pend   <= wr_thr ? 1'b0 : w_thre_set ? 1'b1 :
                             (rd_iir && int_code == 4'b0010) ? 1'b0 : r_thre_pend;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_thresh;
    logic             w_active;
    logic             w_rx_clr;

    // Four character times: start + data + parity + stop bits
    assign w_thresh  = CNT_W'(4 * (7 + 32'(cfg_word_len) + 32'(cfg_parity_en) + 32'(cfg_stop_bit)));
    assign w_active  = cfg_fifo_enable && rx_fifo_count != '0;
    assign w_rx_clr  = rx_push | rd_rhr;
    assign w_cnt_nxt = (!w_active || w_rx_clr) ? '0 :
                       (rx_bit_tick && r_cnt < w_thresh) ? r_cnt + 1'b1 : r_cnt;
    assign w_unused  = cfg_int_en[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_timeout_pend <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_timeout_pend <= w_rx_clr ? 1'b0 : (w_active && w_cnt_nxt >= w_thresh) ? 1'b1 : r_timeout_pend;
        end
    end
`else
    assign r_timeout_pend = 1'b0;
    assign w_unused       = ^{cfg_int_en[3], rx_bit_tick, cfg_word_len, cfg_stop_bit, cfg_parity_en};
`endif
endmodule

// File: tb/tb_uart_intc.sv
// tb_uart_intc: directed scenarios plus randomized traffic checked against a cycle-level model.
// Timeout scenarios follow UART_RX_TIMEOUT_EN, matching the RTL build.
module tb_uart_intc;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cfg_int_en;
    logic       cfg_fifo_enable;
    logic [1:0] cfg_fifo_trig;
    logic [1:0] cfg_word_len;
    logic       cfg_stop_bit;
    logic       cfg_parity_en;
    logic       int_rx_line_status;
    logic       rx_valid;
    logic [4:0] rx_fifo_count;
    logic       rx_push;
    logic       rd_rhr;
    logic       thr_empty;
    logic       wr_thr;
    logic       rd_iir;
    logic       rx_bit_tick;
    logic [3:0] int_code;
    logic       irq;

    int checks = 0;
    int errors = 0;

    uart_intc #(.FIFO_DEPTH(16), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .cfg_int_en(cfg_int_en), .cfg_fifo_enable(cfg_fifo_enable),
        .cfg_fifo_trig(cfg_fifo_trig), .cfg_word_len(cfg_word_len), .cfg_stop_bit(cfg_stop_bit),
        .cfg_parity_en(cfg_parity_en), .int_rx_line_status(int_rx_line_status), .rx_valid(rx_valid),
        .rx_fifo_count(rx_fifo_count), .rx_push(rx_push), .rd_rhr(rd_rhr), .thr_empty(thr_empty),
        .wr_thr(wr_thr), .rd_iir(rd_iir), .rx_bit_tick(rx_bit_tick), .int_code(int_code), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: pending flags and a tick tally since the last RX activity
    logic [3:0] m_code;
    logic       m_irq;
    bit         m_thre, m_to, m_thr_q, m_ier_q;
    int         m_ticks;
    int         trig_tab [4] = '{1, 4, 8, 14};

    always @(posedge clk) begin
        int  thr;
        bit  ls, rda, to, thre, set, active;
        logic [3:0] nc;
        if (rst) begin
            m_code = 4'd1; m_irq = 0; m_thre = 0; m_to = 0; m_ticks = 0; m_thr_q = 1; m_ier_q = 0;
        end else begin
            ls   = cfg_int_en[2] && int_rx_line_status;
            rda  = cfg_int_en[0] && (cfg_fifo_enable ? int'(rx_fifo_count) >= trig_tab[cfg_fifo_trig] : rx_valid);
            to   = cfg_int_en[0] && m_to;
            thre = cfg_int_en[1] && m_thre;
            nc   = ls ? 4'd6 : rda ? 4'd4 : to ? 4'd12 : thre ? 4'd2 : 4'd1;
            set  = (thr_empty && !m_thr_q) || (cfg_int_en[1] && !m_ier_q && thr_empty);
            if (wr_thr) m_thre = 0;
            else if (set) m_thre = 1;
            else if (rd_iir && m_code == 4'd2) m_thre = 0;
`ifdef UART_RX_TIMEOUT_EN
            thr    = 4 * (7 + int'(cfg_word_len) + int'(cfg_parity_en) + int'(cfg_stop_bit));
            active = cfg_fifo_enable && rx_fifo_count != 0;
            if (!active || rx_push || rd_rhr) m_ticks = 0;
            else if (rx_bit_tick && m_ticks < thr) m_ticks++;
            if (rx_push || rd_rhr) m_to = 0;
            else if (active && m_ticks >= thr) m_to = 1;
`endif
            m_code = nc; m_irq = nc != 4'd1; m_thr_q = thr_empty; m_ier_q = cfg_int_en[1];
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin rx_bit_tick = 1; step(1); rx_bit_tick = 0; step(1); end
    endtask

    task automatic test_reset;
        rst = 1; cfg_int_en = 0; cfg_fifo_enable = 0; cfg_fifo_trig = 0; cfg_word_len = 0;
        cfg_stop_bit = 0; cfg_parity_en = 0; int_rx_line_status = 0; rx_valid = 0; rx_fifo_count = 0;
        rx_push = 0; rd_rhr = 0; thr_empty = 1; wr_thr = 0; rd_iir = 0; rx_bit_tick = 0;
        step(3);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL reset_code got %b exp 0001", int_code); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        rst = 0; step(2);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL release_code got %b exp 0001", int_code); end
    endtask

    task automatic test_thre;
        cfg_int_en = 4'b0010; step(2);
        checks++; if (int_code !== 4'b0010) begin errors++; $display("FAIL thre_enable_code got %b exp 0010", int_code); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL thre_enable_irq got %b exp 1", irq); end
        rd_iir = 1; step(1); rd_iir = 0; step(1);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL thre_iir_clear got %b exp 0001", int_code); end
    endtask

    task automatic test_rda;
        cfg_int_en = 4'b0011; cfg_fifo_enable = 1; cfg_fifo_trig = 2'd1; step(2);
        for (int i = 1; i <= 3; i++) begin
            rx_fifo_count = 5'(i); rx_push = 1; step(1); rx_push = 0; step(1);
            checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL rda_below_trig cnt=%0d got %b exp 0001", i, int_code); end
        end
        rx_fifo_count = 4; rx_push = 1; step(1); rx_push = 0; step(1);
        checks++; if (int_code !== 4'b0100) begin errors++; $display("FAIL rda_at_trig got %b exp 0100", int_code); end
        repeat (3) begin rd_rhr = 1; rx_fifo_count = rx_fifo_count - 1; step(1); rd_rhr = 0; end
        step(1);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL rda_drained got %b exp 0001", int_code); end
        rd_rhr = 1; rx_fifo_count = 0; step(1); rd_rhr = 0; step(1);
    endtask

    task automatic test_priority;
        thr_empty = 0; step(1); thr_empty = 1; step(1);
        rx_fifo_count = 4; step(2);
        checks++; if (int_code !== 4'b0100) begin errors++; $display("FAIL prio_rda_over_thre got %b exp 0100", int_code); end
        cfg_int_en = 4'b0111; int_rx_line_status = 1; step(1);
        checks++; if ({int_code, irq} !== 5'b01101) begin errors++; $display("FAIL prio_ls got %b/%b exp 0110/1", int_code, irq); end
        int_rx_line_status = 0; step(1);
        checks++; if (int_code !== 4'b0100) begin errors++; $display("FAIL prio_ls_drop got %b exp 0100", int_code); end
        rd_rhr = 1; rx_fifo_count = 0; step(1); rd_rhr = 0; step(1);
        checks++; if (int_code !== 4'b0010) begin errors++; $display("FAIL prio_thre_left got %b exp 0010", int_code); end
        wr_thr = 1; thr_empty = 0; step(1); wr_thr = 0; step(1);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL prio_wr_thr_clear got %b exp 0001", int_code); end
    endtask

    task automatic test_thre_races;
        cfg_int_en = 4'b0010; cfg_fifo_enable = 0; thr_empty = 0; step(1);
        thr_empty = 1; wr_thr = 1; step(1); wr_thr = 0; step(1);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL race_wr_beats_set got %b exp 0001", int_code); end
        thr_empty = 0; step(1); thr_empty = 1; step(2);
        checks++; if (int_code !== 4'b0010) begin errors++; $display("FAIL race_rise_pending got %b exp 0010", int_code); end
        thr_empty = 0; step(1); thr_empty = 1; rd_iir = 1; step(1); rd_iir = 0; step(1);
        checks++; if (int_code !== 4'b0010) begin errors++; $display("FAIL race_set_beats_iir got %b exp 0010", int_code); end
    endtask

    task automatic test_rst_mid;
        rst = 1; step(1);
        checks++; if ({int_code, irq} !== 5'b00010) begin errors++; $display("FAIL rst_mid got %b/%b exp 0001/0", int_code, irq); end
        thr_empty = 0; rst = 0; step(3);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL rst_mid_thre_cleared got %b exp 0001", int_code); end
        thr_empty = 1; step(2); rd_iir = 1; step(1); rd_iir = 0; step(1);
    endtask

    task automatic test_timeout;
        cfg_int_en = 4'b0001; cfg_fifo_enable = 1; cfg_fifo_trig = 2'd2; cfg_word_len = 3;
        cfg_parity_en = 0; cfg_stop_bit = 0; rx_fifo_count = 2; rx_push = 1; step(1); rx_push = 0; step(1);
`ifdef UART_RX_TIMEOUT_EN
        tick_n(39); step(1);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL to_39_ticks got %b exp 0001", int_code); end
        tick_n(1); step(1);
        checks++; if ({int_code, irq} !== 5'b11001) begin errors++; $display("FAIL to_40_ticks got %b/%b exp 1100/1", int_code, irq); end
        rst = 1; step(1); rst = 0;
        checks++; if ({int_code, irq} !== 5'b00010) begin errors++; $display("FAIL to_rst got %b/%b exp 0001/0", int_code, irq); end
        tick_n(39); step(1);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL to_rst_counter got %b exp 0001", int_code); end
        tick_n(1); step(1);
        checks++; if (int_code !== 4'b1100) begin errors++; $display("FAIL to_again got %b exp 1100", int_code); end
        rd_rhr = 1; rx_fifo_count = 1; step(1); rd_rhr = 0; step(1);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL to_rhr_clear got %b exp 0001", int_code); end
`else
        tick_n(60); step(1);
        checks++; if (int_code !== 4'b0001) begin errors++; $display("FAIL to_absent got %b exp 0001", int_code); end
`endif
        rd_rhr = 1; rx_fifo_count = 0; step(1); rd_rhr = 0; step(1);
    endtask

    task automatic test_random;
        for (int c = 0; c < 3000; c++) begin
            rst                = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) cfg_int_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) cfg_fifo_enable = ~cfg_fifo_enable;
            if ($urandom_range(0, 31) == 0) cfg_fifo_trig = 2'($urandom);
            if ($urandom_range(0, 63) == 0) {cfg_word_len, cfg_stop_bit, cfg_parity_en} = 4'($urandom);
            if ($urandom_range(0, 7) == 0) int_rx_line_status = ~int_rx_line_status;
            if ($urandom_range(0, 7) == 0) rx_valid = ~rx_valid;
            if ($urandom_range(0, 7) == 0) thr_empty = ~thr_empty;
            rx_push     = ($urandom_range(0, 39) == 0) && rx_fifo_count < 16;
            rd_rhr      = !rx_push && ($urandom_range(0, 39) == 0) && rx_fifo_count > 0;
            rx_fifo_count = rx_fifo_count + 5'(rx_push) - 5'(rd_rhr);
            wr_thr      = ($urandom_range(0, 9) == 0);
            rd_iir      = ($urandom_range(0, 4) == 0);
            rx_bit_tick = $urandom_range(0, 1) == 1;
            step(1);
            checks++; if (int_code !== m_code || irq !== m_irq) begin
                errors++; $display("FAIL random cyc=%0d got %b/%b exp %b/%b", c, int_code, irq, m_code, m_irq);
            end
        end
    endtask

    initial begin
        test_reset;
        test_thre;
        test_rda;
        test_priority;
        test_thre_races;
        test_rst_mid;
        test_timeout;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
